// File: rtl/core_pkg.sv
// Shared state encodings and defaults for the core sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    ISSUE    = 3'd2,
    EXEC     = 3'd3,
    WB       = 3'd4,
    IO_OUT   = 3'd5,
    IO_IN    = 3'd6,
    MEM_WAIT = 3'd7
  } core_state_t;

  localparam int unsigned CORE_INSTR_BYTES = 4;

endpackage

// File: rtl/core_seq_perf.sv
// Retired-instruction and stall-cycle counters for the core sequencer (built only with CORE_SEQ_PERF_EN).
module core_seq_perf (
  input  logic        clk,
  input  logic        rstn,
  input  logic        retire,
  input  logic        stall_cycle,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall_cycles
);

  logic [31:0] retired_q;
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (retire)      retired_q      <= retired_q + 32'd1;
      if (stall_cycle) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign perf_retired      = retired_q;
  assign perf_stall_cycles = stall_cycles_q;

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns PC, the per-instruction FSM and UART/memory handshakes.
// Optional perf counters enabled by defining CORE_SEQ_PERF_EN.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int unsigned      PC_W        = 32,
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  parameter int unsigned      INSTR_BYTES = CORE_INSTR_BYTES,
  parameter int unsigned      DATA_W      = 32,
  parameter int unsigned      IN_W        = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              dec_data_out,
  input  logic              dec_data_in,
  input  logic              dec_mem_access,
  input  logic              mem_ready,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_addr,
  input  logic              tx_busy,
  input  logic              rx_valid,
  input  logic [IN_W-1:0]   rx_data,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic              tx_start,
  output logic              rx_ack,
  output logic              in_override,
  output logic [DATA_W-1:0] in_data,
  output logic              wb_en,
  output logic              retire
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam logic [PC_W-1:0] PC_STEP       = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0] PC_ALIGN_MASK = ~PC_W'(INSTR_BYTES - 1);

  core_state_t       state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              tx_start_q, tx_start_d;
  logic              rx_ack_q, rx_ack_d;
  logic              in_override_q, in_override_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              retire_q, retire_d;

  // Strobes default low and only fire on an advancing (unstalled) edge,
  // so a stalled cycle can never leave one asserted.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tx_start_d    = 1'b0;
    rx_ack_d      = 1'b0;
    retire_d      = 1'b0;
    in_override_d = in_override_q;
    in_data_d     = in_data_q;
    if (!stall) begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: state_d = ISSUE;
        ISSUE: begin
          in_override_d = 1'b0;
          in_data_d     = '0;
          if (dec_data_out)     state_d = IO_OUT;
          else if (dec_data_in) state_d = IO_IN;
          else                  state_d = EXEC;
        end
        IO_OUT: begin
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            state_d    = EXEC;
          end
        end
        IO_IN: begin
          if (rx_valid) begin
            in_data_d     = DATA_W'(rx_data);
            in_override_d = 1'b1;
            rx_ack_d      = 1'b1;
            state_d       = EXEC;
          end
        end
        EXEC: begin
          if (dec_mem_access) begin
            state_d = MEM_WAIT;
          end else begin
            state_d  = WB;
            retire_d = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_d  = WB;
            retire_d = 1'b1;
          end
        end
        WB: begin
          pc_d    = branch_taken ? (branch_addr & PC_ALIGN_MASK) : (pc_q + PC_STEP);
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      tx_start_q    <= 1'b0;
      rx_ack_q      <= 1'b0;
      in_override_q <= 1'b0;
      in_data_q     <= '0;
      retire_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      tx_start_q    <= tx_start_d;
      rx_ack_q      <= rx_ack_d;
      in_override_q <= in_override_d;
      in_data_q     <= in_data_d;
      retire_q      <= retire_d;
    end
  end

  assign pc          = pc_q;
  assign state       = state_q;
  assign tx_start    = tx_start_q;
  assign rx_ack      = rx_ack_q;
  assign in_override = in_override_q;
  assign in_data     = in_data_q;
  assign retire      = retire_q;
  assign wb_en       = (state_q == WB) && !stall;

`ifdef CORE_SEQ_PERF_EN
  logic stall_cycle;
  assign stall_cycle = stall
                    || ((state_q == IO_OUT)   && tx_busy)
                    || ((state_q == IO_IN)    && !rx_valid)
                    || ((state_q == MEM_WAIT) && !mem_ready);

  core_seq_perf u_perf (
    .clk               (clk),
    .rstn              (rstn),
    .retire            (retire_q),
    .stall_cycle       (stall_cycle),
    .perf_retired      (perf_retired),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: per-instruction expected cycle traces are queued then popped each cycle.
module tb_core_seq_ctrl;
  import core_pkg::*;

  localparam int K_PLAIN = 0;
  localparam int K_MEM   = 1;
  localparam int K_OUT   = 2;
  localparam int K_IN    = 3;
  localparam int K_BOTH  = 4;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, dec_data_out, dec_data_in, dec_mem_access, mem_ready;
  logic        branch_taken, tx_busy, rx_valid;
  logic [31:0] branch_addr;
  logic [7:0]  rx_data;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        tx_start, rx_ack, in_override, wb_en, retire;
  logic [31:0] in_data;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] perf_retired, perf_stall_cycles;
  logic [31:0] m_perf_ret, m_perf_stall;
`endif

  core_seq_ctrl #(
    .PC_W        (32),
    .RESET_PC    (RST_PC),
    .INSTR_BYTES (4),
    .DATA_W      (32),
    .IN_W        (8)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .dec_data_out   (dec_data_out),
    .dec_data_in    (dec_data_in),
    .dec_mem_access (dec_mem_access),
    .mem_ready      (mem_ready),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .tx_busy        (tx_busy),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .pc             (pc),
    .state          (state),
    .tx_start       (tx_start),
    .rx_ack         (rx_ack),
    .in_override    (in_override),
    .in_data        (in_data),
    .wb_en          (wb_en),
    .retire         (retire)
`ifdef CORE_SEQ_PERF_EN
    ,
    .perf_retired      (perf_retired),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    core_state_t st;
    logic        stl, busy, rxv, mrdy;
  } plan_t;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] pc;
    logic        tx, ack, ret, wb, ovr;
    logic [31:0] ind;
  } exp_t;

  plan_t       pl[$];
  exp_t        exp_q[$];
  logic [31:0] m_pc, m_ind;
  logic        m_ovr;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void pp(core_state_t st, logic stl, logic busy, logic rxv, logic mrdy);
    plan_t p;
    p.st = st; p.stl = stl; p.busy = busy; p.rxv = rxv; p.mrdy = mrdy;
    pl.push_back(p);
  endfunction

  // Builds the cycle plan of one instruction, queues its expected outputs,
  // then drives inputs per cycle and checks each popped record.
  task automatic run_instr(input int kind, input int wait_n, input int stall_n, input logic br,
                           input logic [31:0] baddr, input logic [7:0] rxb, input int abort_at);
    logic        ovr;
    logic [31:0] ind;
    exp_t        e;
    int          n;
    pl.delete();
    pp(FETCH, 0, 0, 0, 0);
    pp(DECODE, 0, 0, 0, 0);
    pp(ISSUE, 0, 0, 0, 0);
    case (kind)
      K_OUT, K_BOTH: begin
        for (int k = 0; k < wait_n; k++)  pp(IO_OUT, 0, 1, 0, 0);
        for (int k = 0; k < stall_n; k++) pp(IO_OUT, 1, 0, 0, 0);
        pp(IO_OUT, 0, 0, 0, 0);
        pp(EXEC, 0, 0, 0, 0);
      end
      K_IN: begin
        for (int k = 0; k < wait_n; k++) pp(IO_IN, 0, 0, 0, 0);
        pp(IO_IN, 0, 0, 1, 0);
        pp(EXEC, 0, 0, 0, 0);
      end
      K_MEM: begin
        pp(EXEC, 0, 0, 0, 0);
        for (int k = 0; k < wait_n; k++) pp(MEM_WAIT, 0, 0, 0, 0);
        pp(MEM_WAIT, 0, 0, 0, 1);
      end
      default: pp(EXEC, 0, 0, 0, 0);
    endcase
    pp(WB, 0, 0, 0, 0);

    ovr = m_ovr;
    ind = m_ind;
    foreach (pl[i]) begin
      e.tx  = 1'b0;
      e.ack = 1'b0;
      if (i > 0 && !pl[i-1].stl) begin
        case (pl[i-1].st)
          ISSUE:  begin ovr = 1'b0; ind = '0; end
          IO_OUT: e.tx = !pl[i-1].busy;
          IO_IN:  if (pl[i-1].rxv) begin ovr = 1'b1; ind = {24'h0, rxb}; e.ack = 1'b1; end
          default: ;
        endcase
      end
      e.st  = pl[i].st;
      e.pc  = m_pc;
      e.ret = (pl[i].st == WB);
      e.wb  = (pl[i].st == WB) && !pl[i].stl;
      e.ovr = ovr;
      e.ind = ind;
      exp_q.push_back(e);
    end

    n = (abort_at >= 0) ? abort_at : pl.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        dec_data_out   = (kind == K_OUT) || (kind == K_BOTH);
        dec_data_in    = (kind == K_IN)  || (kind == K_BOTH);
        dec_mem_access = (kind == K_MEM);
        branch_taken   = br;
        branch_addr    = baddr;
      end
      stall     = pl[i].stl;
      tx_busy   = pl[i].busy;
      rx_valid  = pl[i].rxv;
      rx_data   = rxb;
      mem_ready = pl[i].mrdy;
      e = exp_q.pop_front();
      chk("state",       32'(state),       32'(e.st));
      chk("pc",          pc,               e.pc);
      chk("tx_start",    32'(tx_start),    32'(e.tx));
      chk("rx_ack",      32'(rx_ack),      32'(e.ack));
      chk("retire",      32'(retire),      32'(e.ret));
      chk("wb_en",       32'(wb_en),       32'(e.wb));
      chk("in_override", 32'(in_override), 32'(e.ovr));
      chk("in_data",     in_data,          e.ind);
`ifdef CORE_SEQ_PERF_EN
      chk("perf_retired",      perf_retired,      m_perf_ret);
      chk("perf_stall_cycles", perf_stall_cycles, m_perf_stall);
      m_perf_ret = m_perf_ret + 32'(e.ret);
      if (pl[i].stl || (pl[i].st == IO_OUT && pl[i].busy) ||
          (pl[i].st == IO_IN && !pl[i].rxv) || (pl[i].st == MEM_WAIT && !pl[i].mrdy))
        m_perf_stall = m_perf_stall + 32'd1;
`endif
    end

    if (abort_at >= 0) begin
      exp_q.delete();
    end else begin
      m_pc  = br ? (baddr & ~32'h3) : (m_pc + 32'd4);
      m_ovr = ovr;
      m_ind = ind;
    end
  endtask

  task automatic check_reset_state();
    chk("rst_state",       32'(state),       32'(FETCH));
    chk("rst_pc",          pc,               RST_PC);
    chk("rst_tx_start",    32'(tx_start),    32'h0);
    chk("rst_rx_ack",      32'(rx_ack),      32'h0);
    chk("rst_retire",      32'(retire),      32'h0);
    chk("rst_in_override", 32'(in_override), 32'h0);
    chk("rst_in_data",     in_data,          32'h0);
    chk("rst_wb_en",       32'(wb_en),       32'h0);
`ifdef CORE_SEQ_PERF_EN
    chk("rst_perf_retired", perf_retired,      32'h0);
    chk("rst_perf_stall",   perf_stall_cycles, 32'h0);
`endif
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    m_pc  = RST_PC;
    m_ovr = 1'b0;
    m_ind = '0;
`ifdef CORE_SEQ_PERF_EN
    m_perf_ret   = '0;
    m_perf_stall = '0;
`endif
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; dec_data_out = 1'b0; dec_data_in = 1'b0;
    dec_mem_access = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk);
    check_reset_state();
    release_reset();

    run_instr(K_PLAIN, 0, 0, 1'b0, 32'h0,        8'h00, -1); // 0x100 -> 0x104
    run_instr(K_PLAIN, 0, 0, 1'b1, 32'h2003,     8'h00, -1); // branch, low bits cleared
    run_instr(K_PLAIN, 0, 0, 1'b1, 32'hFFFFFFFE, 8'h00, -1); // to 0xFFFFFFFC
    run_instr(K_PLAIN, 0, 0, 1'b0, 32'h0,        8'h00, -1); // wraps to 0
    run_instr(K_OUT,  10, 0, 1'b0, 32'h0,        8'h00, -1);
    run_instr(K_IN,    7, 0, 1'b0, 32'h0,        8'hA5, -1);
    run_instr(K_PLAIN, 0, 0, 1'b0, 32'h0,        8'h00, -1); // override clears at ISSUE
    run_instr(K_MEM,   2, 0, 1'b0, 32'h0,        8'h00, -1);
    run_instr(K_MEM,   0, 0, 1'b1, 32'h0000_0040, 8'h00, -1);
    run_instr(K_BOTH,  0, 0, 1'b0, 32'h0,        8'h3C, -1); // output wins
    run_instr(K_OUT,   2, 3, 1'b0, 32'h0,        8'h00, -1); // stall with tx_busy low
    run_instr(K_IN,    1, 0, 1'b0, 32'h0,        8'h5A, -1); // leaves in_override set
    run_instr(K_IN,   20, 0, 1'b0, 32'h0,        8'h77, 6);  // abandoned in IO_IN

    #2 rstn = 1'b0;
    #1 check_reset_state();
    release_reset();
    run_instr(K_PLAIN, 0, 0, 1'b0, 32'h0,        8'h00, -1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
